// File: rtl/vref_cal_pkg.sv
// Shared definitions for the MBTRAIN VREF calibration handshake (initiator and responder sides).
// Latency: n/a (package only).
// Backpressure: n/a.
//
// Contents: sideband message codes, responder state encoding.
package vref_cal_pkg;

  // Decoded sideband message codes exchanged between initiator and responder.
  localparam logic [3:0] MSG_NONE       = 4'b0000;
  localparam logic [3:0] MSG_START_REQ  = 4'b0001;
  localparam logic [3:0] MSG_START_RESP = 4'b0010;
  localparam logic [3:0] MSG_END_REQ    = 4'b0011;
  localparam logic [3:0] MSG_END_RESP   = 4'b0100;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_REQ   = 3'd1,
    ST_START_RESP = 3'd2,
    ST_TEST       = 3'd3,
    ST_END_RESP   = 3'd4,
    ST_DONE       = 3'd5
  } state_t;

endpackage

// File: rtl/lane_fail_counter.sv
// Counts failing lanes (zero bits) in a per-lane pass/fail vector.
// Latency: combinational; the parent registers the result.
// Backpressure: none.
//
// Ports:
//   lanes      - per-lane result, 1 = pass, 0 = fail
//   zero_count - number of zero bits in lanes
module lane_fail_counter #(
  parameter int NUM_LANES = 16
) (
  input  logic [NUM_LANES-1:0]         lanes,
  output logic [$clog2(NUM_LANES+1)-1:0] zero_count
);

  localparam int CW = $clog2(NUM_LANES+1);

  always_comb begin
    zero_count = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (!lanes[i]) zero_count = zero_count + CW'(1);
    end
  end

endmodule

// File: rtl/vref_cal_rx.sv
// Responder half of the MBTRAIN VREF calibration handshake: answers START/END requests, runs the RX point test.
// Latency: every output is registered from next-state, so it moves on the same edge as the state register.
// Backpressure: a sent response is held on o_valid_tx until the sideband TX reports a busy negedge while no
//               sibling RX-path block owns the mux (i_valid_rx=0).
//
// Optional feature macro: VREF_CAL_RX_TIMEOUT_EN (TEST timeout; o_timeout tied 0 when undefined).
//
// Ports:
//   clk, rst                      - clock, asynchronous active-high reset
//   i_en                          - sub-state enable; low forces IDLE and clears outputs
//   i_decoded_sideband_message    - partner message code, qualified by i_sideband_valid
//   i_busy_negedge_detected       - sideband TX finished sending
//   i_valid_rx                    - sibling block owns the sideband mux
//   i_mainband_or_valtrain_test   - test type, latched on START_REQ
//   i_pt_done, i_rx_lanes_result  - point test completion pulse and its per-lane result
//   o_sideband_message, o_valid_tx - outgoing response and its request to the TX mux
//   o_pt_en                       - RX point test enable
//   o_mainband_or_valtrain_test   - latched test type
//   o_lanes_result, o_fail_count  - captured lane result and its zero count
//   o_test_ack                    - sub-state complete, held until i_en falls
//   o_timeout                     - TEST timed out waiting for END_REQ
module vref_cal_rx
  import vref_cal_pkg::*;
#(
  parameter int NUM_LANES      = 16,
  parameter int TIMEOUT_CYCLES = 8_000_000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_en,
  input  logic [3:0]                     i_decoded_sideband_message,
  input  logic                           i_sideband_valid,
  input  logic                           i_busy_negedge_detected,
  input  logic                           i_valid_rx,
  input  logic                           i_mainband_or_valtrain_test,
  input  logic                           i_pt_done,
  input  logic [NUM_LANES-1:0]           i_rx_lanes_result,
  output logic [3:0]                     o_sideband_message,
  output logic                           o_valid_tx,
  output logic                           o_pt_en,
  output logic                           o_mainband_or_valtrain_test,
  output logic [NUM_LANES-1:0]           o_lanes_result,
  output logic [$clog2(NUM_LANES+1)-1:0] o_fail_count,
  output logic                           o_test_ack,
  output logic                           o_timeout
);

  localparam int FCW = $clog2(NUM_LANES+1);

  state_t               state_q, state_d;
  logic [3:0]           msg_d;
  logic                 vld_d, pt_en_d, type_d, ack_d, to_d;
  logic [NUM_LANES-1:0] lanes_d;
  logic [FCW-1:0]       fail_d, fail_cnt;
  logic                 to_hit;

  // The TX mux may be serving a sibling RX-path block; only a negedge seen while we own it retires our message.
  wire tx_done   = i_busy_negedge_detected && !i_valid_rx;
  wire start_req = i_sideband_valid && (i_decoded_sideband_message == MSG_START_REQ);
  wire end_req   = i_sideband_valid && (i_decoded_sideband_message == MSG_END_REQ);

  lane_fail_counter #(.NUM_LANES(NUM_LANES)) u_fail_cnt (
    .lanes      (i_rx_lanes_result),
    .zero_count (fail_cnt)
  );

`ifdef VREF_CAL_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES+1);
  logic [TW-1:0] to_cnt_q;

  // Held at zero outside TEST, so it starts from zero on every entry to TEST; saturates at TIMEOUT_CYCLES.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 to_cnt_q <= '0;
    else if (state_q != ST_TEST)             to_cnt_q <= '0;
    else if (to_cnt_q != TW'(TIMEOUT_CYCLES)) to_cnt_q <= to_cnt_q + TW'(1);
  end

  // Fires on the last TEST cycle so DONE lands exactly TIMEOUT_CYCLES after entering TEST.
  assign to_hit = (state_q == ST_TEST) && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    msg_d   = o_sideband_message;
    vld_d   = o_valid_tx;
    pt_en_d = o_pt_en;
    type_d  = o_mainband_or_valtrain_test;
    lanes_d = o_lanes_result;
    fail_d  = o_fail_count;
    ack_d   = o_test_ack;
    to_d    = o_timeout;

    if (!i_en) begin
      state_d = ST_IDLE;
      msg_d   = MSG_NONE;
      vld_d   = 1'b0;
      pt_en_d = 1'b0;
      type_d  = 1'b0;
      lanes_d = '0;
      fail_d  = '0;
      ack_d   = 1'b0;
      to_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_WAIT_REQ;
          lanes_d = '0;
          fail_d  = '0;
        end
        ST_WAIT_REQ: begin
          if (start_req) begin
            state_d = ST_START_RESP;
            msg_d   = MSG_START_RESP;
            vld_d   = 1'b1;
            pt_en_d = 1'b1;
            type_d  = i_mainband_or_valtrain_test;
          end
        end
        ST_START_RESP: begin
          if (tx_done) begin
            state_d = ST_TEST;
            vld_d   = 1'b0;
          end
        end
        ST_TEST: begin
          // Capture first so a result arriving with END_REQ is visible in END_RESP.
          if (i_pt_done) begin
            lanes_d = i_rx_lanes_result;
            fail_d  = fail_cnt;
          end
          if (end_req) begin
            state_d = ST_END_RESP;
            msg_d   = MSG_END_RESP;
            vld_d   = 1'b1;
            pt_en_d = 1'b0;
          end else if (to_hit) begin
            state_d = ST_DONE;
            msg_d   = MSG_NONE;
            pt_en_d = 1'b0;
            ack_d   = 1'b1;
            to_d    = 1'b1;
          end
        end
        ST_END_RESP: begin
          if (tx_done) begin
            state_d = ST_DONE;
            msg_d   = MSG_NONE;
            vld_d   = 1'b0;
            ack_d   = 1'b1;
          end
        end
        ST_DONE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q                     <= ST_IDLE;
      o_sideband_message          <= MSG_NONE;
      o_valid_tx                  <= 1'b0;
      o_pt_en                     <= 1'b0;
      o_mainband_or_valtrain_test <= 1'b0;
      o_lanes_result              <= '0;
      o_fail_count                <= '0;
      o_test_ack                  <= 1'b0;
      o_timeout                   <= 1'b0;
    end else begin
      state_q                     <= state_d;
      o_sideband_message          <= msg_d;
      o_valid_tx                  <= vld_d;
      o_pt_en                     <= pt_en_d;
      o_mainband_or_valtrain_test <= type_d;
      o_lanes_result              <= lanes_d;
      o_fail_count                <= fail_d;
      o_test_ack                  <= ack_d;
      o_timeout                   <= to_d;
    end
  end

endmodule
